// File: rtl/fifo_pkg.sv
// fifo_pkg: shared Gray/binary conversions and burst state type for the async FIFO
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, ACTIVE} burst_state_t;
  // Both functions work on zero-extended 32-bit values; callers truncate to pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/sync_nff.sv
// sync_nff: plain multi-flop CDC synchronizer, async active-low reset
// ports: clk destination clock, rst_n async reset, d async input, q last-stage output
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [STAGES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/wfifo_wlevel.sv
// wfifo_wlevel: write-domain fill level, almost-full, overflow tracking and burst admission
// ports: wclk/wrst_n clock and async reset; rptr_gray in, rptr_gray_sync out (synced read pointer);
//        wptr/wfull/winc from the full-flag stage and producer; wlevel/wspace/walmost_full status;
//        wovf_sticky/wovf_cnt/wovf_clr overflow tracking; burst_req/burst_len/burst_gnt/
//        burst_busy/burst_done/burst_err burst admission handshake
module wfifo_wlevel import fifo_pkg::*; #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_SET      = 12,
  parameter int AF_CLR      = 8,
  parameter int OVF_CNT_W   = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray_sync,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic                  wfull,
  input  logic                  winc,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic [ADDR_WIDTH:0]   wspace,
  output logic                  walmost_full,
  output logic                  wovf_sticky,
  output logic [OVF_CNT_W-1:0]  wovf_cnt,
  input  logic                  wovf_clr,
  input  logic                  burst_req,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  burst_gnt,
  output logic                  burst_busy,
  output logic                  burst_done,
  output logic                  burst_err
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AF_SET_P = PW'(AF_SET);
  localparam logic [PW-1:0] AF_CLR_P = PW'(AF_CLR);
  burst_state_t state;
  logic [PW-1:0] rem, rbin, lvl_next;
  logic ovf_ev, acc;
  sync_nff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk(wclk), .rst_n(wrst_n), .d(rptr_gray), .q(rptr_gray_sync)
  );
  assign rbin = PW'(gray2bin(32'(rptr_gray_sync)));
  // Modular difference stays correct across pointer wrap; the lagging read side only overstates occupancy.
  assign lvl_next = wptr - rbin;
  assign ovf_ev = winc & wfull;
  assign acc = winc & ~wfull;
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wlevel <= '0;
      wspace <= DEPTH_P;
      walmost_full <= 1'b0;
      wovf_sticky <= 1'b0;
      wovf_cnt <= '0;
    end else begin
      wlevel <= lvl_next;
      wspace <= DEPTH_P - lvl_next;
      walmost_full <= lvl_next >= AF_SET_P ? 1'b1 : lvl_next <= AF_CLR_P ? 1'b0 : walmost_full;
      wovf_sticky <= ovf_ev | (wovf_sticky & ~wovf_clr);
      // A clear coinciding with an event restarts the count at that event.
      wovf_cnt <= wovf_clr ? OVF_CNT_W'(ovf_ev) : (ovf_ev & ~&wovf_cnt) ? wovf_cnt + OVF_CNT_W'(1) : wovf_cnt;
    end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      state <= IDLE;
      rem <= '0;
      burst_gnt <= 1'b0;
      burst_busy <= 1'b0;
      burst_done <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      burst_gnt <= 1'b0;
      burst_done <= 1'b0;
      burst_err <= 1'b0;
      // busy trails the ACTIVE state by one cycle: rises after the grant, falls after done.
      burst_busy <= state == ACTIVE;
      case (state)
        IDLE: if (burst_req) begin
          rem <= burst_len;
          if (burst_len == '0 || burst_len > DEPTH_P) burst_err <= 1'b1;
          else state <= WAIT_SPACE;
        end
        WAIT_SPACE: if (wspace >= rem) begin
          burst_gnt <= 1'b1;
          state <= ACTIVE;
        end
        ACTIVE: if (acc) begin
          rem <= rem - PW'(1);
          if (rem == PW'(1)) begin
            burst_done <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wfifo_wlevel.sv
// tb_wfifo_wlevel: directed and randomized checks of wfifo_wlevel against a behavioural model
module tb_wfifo_wlevel;
  localparam int PW = 5, DEPTH = 16, AF_SET = 12, AF_CLR = 8, CW = 8;
  logic wclk = 0, wrst_n = 0;
  logic [PW-1:0] rptr_gray = 0, wptr = 0, burst_len = 0;
  logic winc = 0, wfull = 0, wovf_clr = 0, burst_req = 0;
  logic [PW-1:0] rptr_gray_sync, wlevel, wspace;
  logic walmost_full, wovf_sticky, burst_gnt, burst_busy, burst_done, burst_err;
  logic [CW-1:0] wovf_cnt;
  int n_tests = 0, n_fail = 0;

  wfifo_wlevel #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AF_SET(AF_SET), .AF_CLR(AF_CLR), .OVF_CNT_W(CW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rptr_gray(rptr_gray), .rptr_gray_sync(rptr_gray_sync),
    .wptr(wptr), .wfull(wfull), .winc(winc), .wlevel(wlevel), .wspace(wspace),
    .walmost_full(walmost_full), .wovf_sticky(wovf_sticky), .wovf_cnt(wovf_cnt), .wovf_clr(wovf_clr),
    .burst_req(burst_req), .burst_len(burst_len), .burst_gnt(burst_gnt), .burst_busy(burst_busy),
    .burst_done(burst_done), .burst_err(burst_err)
  );

  always #5 wclk = ~wclk;

  function automatic int decode(input logic [PW-1:0] g);
    for (int i = 0; i < 32; i++) if (((i ^ (i >> 1)) & 31) == int'(g)) return i;
    return 0;
  endfunction
  function automatic logic [PW-1:0] enc(input int b);
    return PW'((b ^ (b >> 1)) & 31);
  endfunction

  logic [PW-1:0] seen [2] = '{0, 0};
  int m_lvl = 0, m_space = DEPTH, m_events = 0, m_phase = 0, m_rem = 0;
  bit m_af = 0, m_sticky = 0, m_gnt = 0, m_busy = 0, m_done = 0, m_err = 0, m_acc, m_ev;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      seen = '{0, 0};
      m_lvl = 0; m_space = DEPTH; m_events = 0; m_phase = 0; m_rem = 0;
      m_af = 0; m_sticky = 0; m_gnt = 0; m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      m_acc = winc && !wfull;
      m_ev = winc && wfull;
      m_gnt = 0; m_done = 0; m_err = 0;
      m_busy = (m_phase == 2);
      if (m_phase == 0) begin
        if (burst_req) begin
          m_rem = int'(burst_len);
          if (m_rem == 0 || m_rem > DEPTH) m_err = 1; else m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_space >= m_rem) begin m_gnt = 1; m_phase = 2; end
      end else if (m_acc) begin
        m_rem--;
        if (m_rem == 0) begin m_done = 1; m_phase = 0; end
      end
      if (wovf_clr) m_events = m_ev ? 1 : 0; else if (m_ev) m_events++;
      m_sticky = m_ev || (m_sticky && !wovf_clr);
      m_lvl = (int'(wptr) - decode(seen[1])) & 31;
      m_space = (DEPTH - m_lvl) & 31;
      if (m_lvl >= AF_SET) m_af = 1; else if (m_lvl <= AF_CLR) m_af = 0;
      seen[1] = seen[0];
      seen[0] = rptr_gray;
    end
  end

  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic test_reset();
    wrst_n = 0;
    tick(); tick();
    n_tests++; if (wlevel !== 5'd0) begin n_fail++; $display("FAIL reset_wlevel got %0d want 0", wlevel); end
    n_tests++; if (wspace !== 5'd16) begin n_fail++; $display("FAIL reset_wspace got %0d want 16", wspace); end
    n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", walmost_full); end
    n_tests++; if (wovf_cnt !== 8'd0 || wovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got cnt=%0d sticky=%b want 0/0", wovf_cnt, wovf_sticky); end
    n_tests++; if ({burst_gnt, burst_busy, burst_done, burst_err} !== 4'b0) begin n_fail++; $display("FAIL reset_burst got %b want 0000", {burst_gnt, burst_busy, burst_done, burst_err}); end
    n_tests++; if (rptr_gray_sync !== 5'd0) begin n_fail++; $display("FAIL reset_sync got %0d want 0", rptr_gray_sync); end
    wrst_n = 1; wptr = 5; rptr_gray = 0;
    tick();
    n_tests++; if (wlevel !== 5'd5 || wspace !== 5'd11) begin n_fail++; $display("FAIL first_level got %0d/%0d want 5/11", wlevel, wspace); end
  endtask

  task automatic test_sync();
    rptr_gray = 5'b00010;
    tick();
    n_tests++; if (rptr_gray_sync !== 5'd0) begin n_fail++; $display("FAIL sync_edge1 got %b want 00000", rptr_gray_sync); end
    tick();
    n_tests++; if (rptr_gray_sync !== 5'b00010 || wlevel !== 5'd5) begin n_fail++; $display("FAIL sync_edge2 got sync=%b lvl=%0d want 00010/5", rptr_gray_sync, wlevel); end
    tick();
    n_tests++; if (wlevel !== 5'd2 || wspace !== 5'd14) begin n_fail++; $display("FAIL sync_edge3 got %0d/%0d want 2/14", wlevel, wspace); end
  endtask

  task automatic test_wrap();
    wptr = 2; rptr_gray = 5'b11011;
    tick(); tick(); tick();
    n_tests++; if (wlevel !== 5'd16 || wspace !== 5'd0) begin n_fail++; $display("FAIL wrap_level got %0d/%0d want 16/0", wlevel, wspace); end
    n_tests++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL wrap_af got %b want 1", walmost_full); end
  endtask

  task automatic test_hysteresis();
    int lv[5] = '{11, 12, 9, 8, 9};
    bit ex[5] = '{0, 1, 1, 0, 0};
    wptr = 0; rptr_gray = 0;
    tick(); tick(); tick();
    n_tests++; if (wlevel !== 5'd0 || walmost_full !== 1'b0) begin n_fail++; $display("FAIL hyst_base got lvl=%0d af=%b want 0/0", wlevel, walmost_full); end
    for (int i = 0; i < 5; i++) begin
      wptr = PW'(lv[i]);
      tick();
      n_tests++; if (wlevel !== PW'(lv[i]) || walmost_full !== ex[i]) begin n_fail++; $display("FAIL hyst_step%0d got lvl=%0d af=%b want %0d/%b", i, wlevel, walmost_full, lv[i], ex[i]); end
    end
  endtask

  task automatic test_burst();
    int gnts = 0, n_acc = 0;
    bit pat[8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    wptr = 12;
    tick();
    n_tests++; if (wspace !== 5'd4) begin n_fail++; $display("FAIL burst_space got %0d want 4", wspace); end
    burst_req = 1; burst_len = 6;
    tick();
    burst_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (burst_gnt !== 1'b0 || burst_busy !== 1'b0) begin n_fail++; $display("FAIL burst_wait%0d got gnt=%b busy=%b want 0/0", i, burst_gnt, burst_busy); end
    end
    wptr = 10;
    for (int i = 0; i < 10; i++) begin
      tick();
      gnts += int'(burst_gnt);
      n_tests++; if (burst_gnt !== m_gnt) begin n_fail++; $display("FAIL burst_gnt_cyc%0d got %b want %b", i, burst_gnt, m_gnt); end
    end
    n_tests++; if (gnts != 1 || burst_busy !== 1'b1) begin n_fail++; $display("FAIL burst_grant got pulses=%0d busy=%b want 1/1", gnts, burst_busy); end
    for (int i = 0; i < 8; i++) begin
      winc = 1; wfull = pat[i];
      tick();
      if (!pat[i]) n_acc++;
      n_tests++; if (burst_done !== (n_acc == 6) || burst_busy !== 1'b1) begin n_fail++; $display("FAIL burst_word%0d got done=%b busy=%b want %b/1", i, burst_done, burst_busy, n_acc == 6); end
    end
    winc = 0; wfull = 0;
    tick();
    n_tests++; if (burst_busy !== 1'b0 || burst_done !== 1'b0) begin n_fail++; $display("FAIL burst_end got busy=%b done=%b want 0/0", burst_busy, burst_done); end
    burst_req = 1; burst_len = 0;
    tick();
    n_tests++; if (burst_err !== 1'b1 || burst_busy !== 1'b0) begin n_fail++; $display("FAIL burst_len0 got err=%b busy=%b want 1/0", burst_err, burst_busy); end
    burst_len = 17;
    tick();
    n_tests++; if (burst_err !== 1'b1) begin n_fail++; $display("FAIL burst_len17 got err=%b want 1", burst_err); end
    burst_req = 0;
    tick();
    n_tests++; if (burst_err !== 1'b0 || burst_gnt !== 1'b0) begin n_fail++; $display("FAIL burst_err_idle got err=%b gnt=%b want 0/0", burst_err, burst_gnt); end
    burst_req = 1; burst_len = 3;
    tick();
    burst_req = 0;
    tick();
    n_tests++; if (burst_gnt !== 1'b1) begin n_fail++; $display("FAIL burst_after_err got gnt=%b want 1", burst_gnt); end
    tick();
    wrst_n = 0;
    #1;
    n_tests++; if (burst_busy !== 1'b0 || wlevel !== 5'd0) begin n_fail++; $display("FAIL burst_async_rst got busy=%b lvl=%0d want 0/0", burst_busy, wlevel); end
    tick();
    wrst_n = 1;
    tick();
    n_tests++; if (burst_busy !== 1'b0 || burst_done !== 1'b0 || wlevel !== 5'd10) begin n_fail++; $display("FAIL burst_post_rst got busy=%b done=%b lvl=%0d want 0/0/10", burst_busy, burst_done, wlevel); end
  endtask

  task automatic test_overflow();
    wovf_clr = 1;
    tick();
    wovf_clr = 0;
    n_tests++; if (wovf_cnt !== 8'd0 || wovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0d/%b want 0/0", wovf_cnt, wovf_sticky); end
    winc = 1; wfull = 1;
    tick(); tick(); tick();
    n_tests++; if (wovf_cnt !== 8'd3 || wovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_three got %0d/%b want 3/1", wovf_cnt, wovf_sticky); end
    wovf_clr = 1;
    tick();
    wovf_clr = 0;
    n_tests++; if (wovf_cnt !== 8'd1 || wovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_event got %0d/%b want 1/1", wovf_cnt, wovf_sticky); end
    for (int i = 0; i < 300; i++) tick();
    n_tests++; if (wovf_cnt !== 8'd255 || wovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_saturate got %0d/%b want 255/1", wovf_cnt, wovf_sticky); end
    winc = 0; wfull = 0; wovf_clr = 1;
    tick();
    wovf_clr = 0;
    n_tests++; if (wovf_cnt !== 8'd0 || wovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_alone got %0d/%b want 0/0", wovf_cnt, wovf_sticky); end
  endtask

  task automatic test_random();
    int rb;
    for (int it = 0; it < 60; it++) begin
      rb = int'($urandom_range(0, 31));
      wptr = PW'((rb + int'($urandom_range(0, 16))) & 31);
      rptr_gray = enc(rb);
      for (int c = 0; c < 3; c++) begin
        winc = 1'($urandom_range(0, 1));
        wfull = ($urandom_range(0, 3) == 0);
        wovf_clr = ($urandom_range(0, 7) == 0);
        burst_req = ($urandom_range(0, 3) == 0);
        burst_len = PW'($urandom_range(0, 17));
        tick();
        n_tests++; if (wlevel !== PW'(m_lvl) || wspace !== PW'(m_space) || walmost_full !== m_af) begin n_fail++; $display("FAIL rand_level it%0d got %0d/%0d/%b want %0d/%0d/%b", it, wlevel, wspace, walmost_full, m_lvl, m_space, m_af); end
        n_tests++; if (wovf_sticky !== m_sticky || wovf_cnt !== CW'(m_events > 255 ? 255 : m_events)) begin n_fail++; $display("FAIL rand_ovf it%0d got %b/%0d want %b/%0d", it, wovf_sticky, wovf_cnt, m_sticky, m_events > 255 ? 255 : m_events); end
        n_tests++; if ({burst_gnt, burst_busy, burst_done, burst_err} !== {m_gnt, m_busy, m_done, m_err}) begin n_fail++; $display("FAIL rand_burst it%0d got %b want %b", it, {burst_gnt, burst_busy, burst_done, burst_err}, {m_gnt, m_busy, m_done, m_err}); end
      end
    end
    winc = 0; wfull = 0; wovf_clr = 0; burst_req = 0;
  endtask

  initial begin
    @(negedge wclk);
    test_reset();
    test_sync();
    test_wrap();
    test_hysteresis();
    test_burst();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/wfifo_wlevel.md
Name: wfifo_wlevel

Overview:
- Write-domain companion to the write-pointer/full-flag stage of the async FIFO.
- Synchronizes the read-domain Gray pointer into wclk and hands it to the full-flag stage as rptr_gray_sync.
- Computes registered fill level, free space and a hysteretic almost-full flag, and tracks overflow attempts.
- Provides a burst-admission handshake that grants a producer burst only when enough space is guaranteed.

Parameters:
- ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH.
- SYNC_STAGES, 2, flop stages in the rptr CDC synchronizer; legal range is 2 or more.
- AF_SET, 12, level at or above which walmost_full asserts.
- AF_CLR, 8, level at or below which walmost_full deasserts; AF_CLR < AF_SET ≤ DEPTH.
- OVF_CNT_W, 8, overflow counter width.

Ports:
- wclk  in  1  write clock
- wrst_n  in  1  reset, asynchronous, active-low
- rptr_gray  in  ADDR_WIDTH+1  read pointer, Gray, from rclk domain
- rptr_gray_sync  out  ADDR_WIDTH+1  synchronized read Gray pointer, to full-flag stage
- wptr  in  ADDR_WIDTH+1  registered binary write pointer from full-flag stage
- wfull  in  1  full flag from full-flag stage
- winc  in  1  producer write request
- wlevel  out  ADDR_WIDTH+1  occupied entries, range 0..DEPTH
- wspace  out  ADDR_WIDTH+1  free entries, DEPTH-wlevel
- walmost_full  out  1  hysteretic almost-full
- wovf_sticky  out  1  overflow seen (winc while wfull)
- wovf_cnt  out  OVF_CNT_W  saturating overflow count
- wovf_clr  in  1  clears overflow sticky and count
- burst_req  in  1  burst request, level-sensitive
- burst_len  in  ADDR_WIDTH+1  requested words, legal range 1..DEPTH
- burst_gnt  out  1  one-cycle grant pulse
- burst_busy  out  1  burst granted and in progress
- burst_done  out  1  one-cycle pulse on the final accepted word
- burst_err  out  1  one-cycle pulse on an illegal length

Behaviour:
- Reset (async, wrst_n=0): all sync flops, rptr_gray_sync, wlevel, walmost_full, wovf_*, burst_* outputs = 0; wspace = DEPTH; FSM = IDLE. Reset asserted mid-burst aborts the burst with no done pulse.
- Synchronizer: a plain SYNC_STAGES-deep flop chain with no logic between stages; rptr_gray_sync is the last stage. Latency is SYNC_STAGES wclk edges.
- Gray-to-binary: rbin[MSB] = g[MSB]; rbin[i] = rbin[i+1] ^ g[i]. Applied to rptr_gray_sync, combinational.
- Level: lvl_next = (wptr - rbin) modulo 2^(ADDR_WIDTH+1). This gives correct results across pointer wrap; result ≤ DEPTH by construction. wlevel and wspace are registered, so each updates 1 cycle after a wptr or rptr_gray_sync change.
- The level is pessimistic (read side lags) and must never undercount occupancy.
- Almost-full:
  - Set when lvl_next ≥ AF_SET.
  - Clear when lvl_next ≤ AF_CLR.
  - Otherwise hold.
  - Registered alongside wlevel.
- Overflow: an event is winc & wfull in a cycle.
  - On an event: wovf_sticky <= 1 and wovf_cnt increments, saturating at all-ones.
  - wovf_clr alone: both clear to 0.
  - wovf_clr and an event in the same cycle: sticky = 1, cnt = 1.
- Accepted write: acc = winc & ~wfull.
- Burst FSM, states IDLE, WAIT_SPACE, ACTIVE:
  - IDLE, burst_req=1: latch burst_len into rem.
    - len == 0 or len > DEPTH: pulse burst_err, stay IDLE.
    - Otherwise go to WAIT_SPACE.
  - WAIT_SPACE: when registered wspace ≥ rem, pulse burst_gnt, assert burst_busy from the next cycle, go to ACTIVE. burst_req is ignored here.
  - ACTIVE: each acc decrements rem. When acc occurs with rem == 1: pulse burst_done in that same cycle, deassert burst_busy next cycle, go to IDLE.
  - A new burst_req is sampled no earlier than the cycle after return to IDLE.
  - acc outside ACTIVE does not affect the FSM.
- All outputs are registered except rptr_gray_sync, which is a flop output.

Decomposition:
- Shared package fifo_pkg holds:
  - the gray2bin function
  - the bin2gray function
  - the burst state enum type burst_state_t (IDLE, WAIT_SPACE, ACTIVE)
- One sub-module: sync_nff (parameterized width and stage count, async active-low reset). It is reused for the mirrored read-side synchronizer.

Test Plan (ADDR_WIDTH=4, DEPTH=16, AF_SET=12, AF_CLR=8, SYNC_STAGES=2):
1. Reset → wlevel=0, wspace=16, walmost_full=0, wovf_cnt=0, all burst outputs 0. Then hold wptr=5, rptr_gray=0 → wlevel=5, wspace=11 one cycle later.
2. Change rptr_gray to 5'b00010 (binary 3) with wptr=5 → rptr_gray_sync updates after 2 edges; wlevel=2 on the 3rd edge.
3. Wrap: wptr=2, rptr_gray=5'b11011 (binary 18) → wlevel=16, wspace=0.
4. Hysteresis: step the level 11 → 12 → 9 → 8 → 9. Required walmost_full: 0, 1, 1, 0, 0.
5. Burst: wspace=4, burst_req with burst_len=6 → no gnt until wspace ≥ 6, then a single gnt pulse and busy=1. Drive 6 winc with wfull=0, plus 2 cycles with wfull=1 mid-burst → done pulses on the 6th accepted word, busy drops next cycle. Separately, burst_len=0 → burst_err pulse and FSM stays IDLE.
6. Overflow: 3 cycles of winc & wfull → sticky=1, cnt=3. Then wovf_clr together with winc & wfull → cnt=1, sticky=1. Then 300 events → cnt saturates at 255.
